pixel_dispatcher: RTL

// - Frame-level controller directly upstream of the iterator.
// - Walks a WIDTH x HEIGHT pixel raster and issues one (cr, ci) point per pixel to the iterator.
// - Acks the iterator's done, turns its iteration count into an 8-bit colour and writes that colour to the frame buffer.
// - Fixed point is 27-bit signed 4.23, matching the iterator's c/z format.

---
 rtl/pixel_dispatcher_if.sv | 27 ++
 rtl/pixel_dispatcher.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/pixel_dispatcher_if.sv
// Iterator and frame-buffer channels of the pixel dispatcher.
// The master modport is the dispatcher side. The slave modport is the iterator/frame-buffer side.
interface pixel_dispatcher_if #(
    parameter int AW = 19
);
    logic [26:0]   it_cr;
    logic [26:0]   it_ci;
    logic [31:0]   it_max;
    logic          it_load;
    logic          it_done;
    logic [31:0]   it_iterations;
    logic          it_ack;
    logic          fb_we;
    logic [AW-1:0] fb_addr;
    logic [7:0]    fb_data;
    logic          fb_ready;

    modport master (
        output it_cr, it_ci, it_max, it_load, it_ack, fb_we, fb_addr, fb_data,
        input  it_done, it_iterations, fb_ready
    );

    modport slave (
        input  it_cr, it_ci, it_max, it_load, it_ack, fb_we, fb_addr, fb_data,
        output it_done, it_iterations, fb_ready
    );
endinterface

// File: rtl/pixel_dispatcher.sv
// Frame controller: walks a WIDTH x HEIGHT raster, feeds (cr, ci) to the iterator, and writes 8-bit colours.
// Optional DISPATCH_PERF_EN adds a saturating perf_cycles counter of busy cycles per frame.
module pixel_dispatcher #(
    parameter int WIDTH  = 640,
    parameter int HEIGHT = 480,
    parameter int AW     = 19
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [26:0] cr_left,
    input  logic [26:0] ci_top,
    input  logic [26:0] dx,
    input  logic [26:0] dy,
    input  logic [31:0] max_iter,
    pixel_dispatcher_if.master bus,
    output logic        busy,
    output logic        frame_done
`ifdef DISPATCH_PERF_EN
    ,
    output logic [31:0] perf_cycles
`endif
);

    localparam int XW = (WIDTH  > 1) ? $clog2(WIDTH)  : 1;
    localparam int YW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
    localparam logic [XW-1:0] X_LAST = XW'(WIDTH - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(HEIGHT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_WAIT,
        S_ACK,
        S_WRITE,
        S_ADVANCE,
        S_DONE
    } state_t;

    state_t        r_state;
    state_t        w_next;
    logic [XW-1:0] r_x;
    logic [YW-1:0] r_y;
    logic [AW-1:0] r_addr;
    logic [26:0]   r_cr;
    logic [26:0]   r_ci;
    logic [26:0]   r_cr_left;
    logic [26:0]   r_dx;
    logic [26:0]   r_dy;
    logic [31:0]   r_max;
    logic [7:0]    r_color;
    logic [7:0]    w_color;
    logic          w_last;

    assign w_last = (r_x == X_LAST) && (r_y == Y_LAST);

    // NOTE: non-blocking (<=) for every register so all flops update from pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // NOTE: default assigned first so no path leaves w_next unassigned (no latch).
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:    if (start) w_next = S_LOAD;
            S_LOAD:    w_next = S_WAIT;
            S_WAIT:    if (bus.it_done) w_next = S_ACK;
            S_ACK:     w_next = S_WRITE;
            S_WRITE:   if (bus.fb_ready) w_next = w_last ? S_DONE : S_ADVANCE;
            S_ADVANCE: w_next = S_LOAD;
            S_DONE:    w_next = S_IDLE;
            default:   w_next = S_IDLE;
        endcase
    end

    // Iterations at or above the escape limit mean "in set" and take priority over the clamp.
    always_comb begin
        w_color = bus.it_iterations[7:0];
        if (bus.it_iterations >= r_max) begin
            w_color = 8'h00;
        end else if (bus.it_iterations >= 32'd255) begin
            w_color = 8'hFF;
        end else if (bus.it_iterations == 32'd0) begin
            w_color = 8'h01;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_x       <= '0;
            r_y       <= '0;
            r_addr    <= '0;
            r_cr      <= '0;
            r_ci      <= '0;
            r_cr_left <= '0;
            r_dx      <= '0;
            r_dy      <= '0;
            r_max     <= '0;
            r_color   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_cr      <= cr_left;
                        r_ci      <= ci_top;
                        r_cr_left <= cr_left;
                        r_dx      <= dx;
                        r_dy      <= dy;
                        r_max     <= max_iter;
                        r_x       <= '0;
                        r_y       <= '0;
                        r_addr    <= '0;
                    end
                end
                S_WAIT: begin
                    if (bus.it_done) r_color <= w_color;
                end
                S_WRITE: begin
                    if (bus.fb_ready) r_addr <= r_addr + AW'(1);
                end
                S_ADVANCE: begin
                    // Stepping incrementally keeps the datapath free of multipliers.
                    if (r_x != X_LAST) begin
                        r_x  <= r_x + XW'(1);
                        r_cr <= r_cr + r_dx;
                    end else begin
                        r_x  <= '0;
                        r_cr <= r_cr_left;
                        r_y  <= r_y + YW'(1);
                        r_ci <= r_ci - r_dy;
                    end
                end
                S_DONE: begin
                    r_x    <= '0;
                    r_y    <= '0;
                    r_addr <= '0;
                end
                default: ;
            endcase
        end
    end

    assign bus.it_cr   = r_cr;
    assign bus.it_ci   = r_ci;
    assign bus.it_max  = r_max;
    assign bus.it_load = (r_state == S_LOAD);
    assign bus.it_ack  = (r_state == S_ACK);
    assign bus.fb_we   = (r_state == S_WRITE);
    assign bus.fb_addr = r_addr;
    assign bus.fb_data = r_color;
    assign busy        = (r_state != S_IDLE) && (r_state != S_DONE);
    assign frame_done  = (r_state == S_DONE);

`ifdef DISPATCH_PERF_EN
    logic [31:0] r_perf;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_perf <= '0;
        end else if ((r_state == S_IDLE) && start) begin
            r_perf <= '0;
        end else if (busy && (r_perf != 32'hFFFF_FFFF)) begin
            r_perf <= r_perf + 32'd1;
        end
    end

    assign perf_cycles = r_perf;
`endif

endmodule
